// File: rtl/parity_pkg.sv
// Shared definitions for the parity serial transmitter and its bus-side parity checker.
// State encoding, parity-mode constants and frame overhead live here so both sides agree.
package parity_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Start, parity and stop bits added around the data word.
  localparam int FRAME_OVH = 3;

  // sel=PAR_EVEN makes data+parity carry an even number of ones.
  function automatic logic parity_bit(input logic data_xor, input logic mode);
    return data_xor ^ mode;
  endfunction

  function automatic int div_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/baud_div.sv
// Bit-period divider: strobes bit_end on the last clk of every CLKS_PER_BIT-cycle bit.
// next_end looks one cycle ahead so the owner can register a pulse aligned with that last cycle.
module baud_div
  import parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic bit_end,
  output logic next_end
);

  localparam int DW = div_width(CLKS_PER_BIT);
  localparam logic [DW-1:0] LAST = DW'(CLKS_PER_BIT - 1);

  logic [DW-1:0] cnt_reg;
  logic [DW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  assign bit_end  = en && !clear && (cnt_reg == LAST);
  assign next_end = (cnt_next == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/parity_ser_tx.sv
// Serial transmitter: start(0), DATA_W data bits LSB first, parity, stop(1); line idles high.
// Word and parity mode are captured at acceptance so later bus/sel changes cannot disturb a frame.
module parity_ser_tx
  import parity_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus,
  input  logic              sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            state_reg;
  logic [DATA_W-1:0] shreg_reg;
  logic [DATA_W-1:0] shreg_shift;
  logic [BW-1:0]     bitcnt_reg;
  logic              par_reg;
  logic              tx_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              accept;
  logic              bit_end;
  logic              next_end;

  assign in_ready    = (state_reg == IDLE) && !rst;
  assign accept      = in_valid && in_ready;
  assign shreg_shift = shreg_reg >> 1;

  baud_div #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_div (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .en      (busy_reg),
    .bit_end (bit_end),
    .next_end(next_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      shreg_reg  <= '0;
      bitcnt_reg <= '0;
      par_reg    <= 1'b0;
      tx_reg     <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          tx_reg <= 1'b1;
          if (accept) begin
            shreg_reg  <= bus;
            par_reg    <= parity_bit(^bus, sel);
            bitcnt_reg <= '0;
            tx_reg     <= 1'b0;
            busy_reg   <= 1'b1;
            state_reg  <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx_reg    <= shreg_reg[0];
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bitcnt_reg == LAST_BIT) begin
              tx_reg    <= par_reg;
              state_reg <= PARITY;
            end else begin
              shreg_reg  <= shreg_shift;
              tx_reg     <= shreg_shift[0];
              bitcnt_reg <= bitcnt_reg + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx_reg    <= 1'b1;
            state_reg <= STOP;
            // With a one-cycle bit the stop bit's only cycle is also its last.
            done_reg  <= next_end;
          end
        end
        STOP: begin
          if (bit_end) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            done_reg <= next_end;
          end
        end
        default: begin
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign tx   = tx_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_parity_ser_tx.sv
// Bench for parity_ser_tx: two instances (CLKS_PER_BIT 4 and 1) checked cycle by cycle against
// a frame built from the word, mode and bit period, then deserialised and parity-checked.
module tb_parity_ser_tx;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         sel;
  logic         in_valid;
  logic [W-1:0] bus;
  logic         inst;

  logic v0, v1;
  logic rdy0, tx0, busy0, done0;
  logic rdy1, tx1, busy1, done1;
  logic rdy_m, tx_m, busy_m, done_m;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign v0     = in_valid && !inst;
  assign v1     = in_valid && inst;
  assign rdy_m  = inst ? rdy1  : rdy0;
  assign tx_m   = inst ? tx1   : tx0;
  assign busy_m = inst ? busy1 : busy0;
  assign done_m = inst ? done1 : done0;

  parity_ser_tx #(.DATA_W(W), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sel(sel), .in_valid(v0),
    .in_ready(rdy0), .tx(tx0), .busy(busy0), .done(done0)
  );

  parity_ser_tx #(.DATA_W(W), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus), .sel(sel), .in_valid(v1),
    .in_ready(rdy1), .tx(tx1), .busy(busy1), .done(done1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // mode 0: plain, 1: keep in_valid high with the next word, 2: scramble bus/sel mid-frame
  task automatic frame(input logic [W-1:0] word, input logic s, input int mode,
                       input logic [W-1:0] nword, input logic ns);
    int       cpb;
    int       nc;
    int       b;
    logic     bits[$];
    logic [W-1:0] cap;
    logic     cap_par;
    logic     exp_par;
    cpb     = inst ? 1 : 4;
    nc      = (W + 3) * cpb;
    exp_par = logic'(($countones(word) + int'(s)) % 2);
    cap     = '0;
    cap_par = 1'b0;
    bits    = {};
    bits.push_back(1'b0);
    for (int k = 0; k < W; k++) bits.push_back(word[k]);
    bits.push_back(exp_par);
    bits.push_back(1'b1);

    check1("ready_before_accept", rdy_m, 1'b1);
    bus = word; sel = s; in_valid = 1'b1;
    tick;
    if (mode == 1) begin
      bus = nword; sel = ns;
    end else begin
      in_valid = 1'b0;
    end
    for (int i = 1; i <= nc; i++) begin
      b = (i - 1) / cpb;
      check1($sformatf("tx@%0d", i), tx_m, bits[b]);
      check1($sformatf("busy@%0d", i), busy_m, 1'b1);
      check1($sformatf("done@%0d", i), done_m, i == nc);
      check1($sformatf("ready@%0d", i), rdy_m, 1'b0);
      if ((i - 1) % cpb == 0) begin
        if (b >= 1 && b <= W) cap[b-1] = tx_m;
        if (b == W + 1) cap_par = tx_m;
      end
      if (mode == 2 && i % 20 == 0) begin
        bus = $urandom;
        sel = ~sel;
      end
      tick;
    end
    check1("idle_tx", tx_m, 1'b1);
    check1("idle_busy", busy_m, 1'b0);
    check1("idle_done", done_m, 1'b0);
    check1("idle_ready", rdy_m, 1'b1);
    checkw("deser_word", cap, word);
    check1("deser_parity_ok", (^cap) ^ cap_par, s);
    $display("frame cpb=%0d word=%h sel=%0b parity=%0b mode=%0d", cpb, word, s, exp_par, mode);
  endtask

  task automatic abort_frame(input logic [W-1:0] word);
    int cpb;
    cpb = inst ? 1 : 4;
    check1("abort_ready", rdy_m, 1'b1);
    bus = word; sel = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (11 * cpb) tick;
    check1("abort_tx_bit10", tx_m, word[10]);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    check1("abort_tx", tx_m, 1'b1);
    check1("abort_busy", busy_m, 1'b0);
    check1("abort_done", done_m, 1'b0);
    check1("abort_ready_after", rdy_m, 1'b1);
    for (int i = 0; i < (W + 3) * cpb; i++) begin
      check1($sformatf("abort_nodone@%0d", i), done_m, 1'b0);
      check1($sformatf("abort_line@%0d", i), tx_m, 1'b1);
      tick;
    end
    $display("abort cpb=%0d word=%h at data bit 10", cpb, word);
  endtask

  initial begin
    logic [W-1:0] wa, wb;
    logic         sa, sb;
    inst = 1'b0; rst = 1'b1; in_valid = 1'b1; bus = $urandom; sel = 1'b0;
    tick;
    check1("rst1_tx", tx_m, 1'b1);
    check1("rst1_busy", busy_m, 1'b0);
    check1("rst1_done", done_m, 1'b0);
    check1("rst1_ready_low", rdy_m, 1'b0);
    tick;
    check1("rst2_tx", tx_m, 1'b1);
    check1("rst2_busy", busy_m, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check1("rst_release_ready", rdy_m, 1'b1);
    tick;
    check1("no_accept_in_rst", busy_m, 1'b0);
    check1("no_accept_tx", tx_m, 1'b1);
    $display("reset checked");

    frame(32'h0000_0001, 1'b0, 0, '0, 1'b0);
    frame(32'h0000_0003, 1'b1, 0, '0, 1'b0);
    frame(32'h0000_0003, 1'b0, 0, '0, 1'b0);
    frame(32'hFFFF_FFFF, 1'b1, 0, '0, 1'b0);
    frame(32'h0000_0000, 1'b0, 0, '0, 1'b0);
    repeat (4) frame($urandom, 1'($urandom_range(1)), 0, '0, 1'b0);
    frame(32'h0000_0005, 1'b0, 2, '0, 1'b0);

    wa = $urandom; wb = $urandom; sa = 1'($urandom_range(1)); sb = ~sa;
    frame(wa, sa, 1, wb, sb);
    frame(wb, sb, 0, '0, 1'b0);

    abort_frame($urandom);
    frame($urandom, 1'b1, 0, '0, 1'b0);

    inst = 1'b1;
    tick;
    frame(32'h0000_0001, 1'b0, 0, '0, 1'b0);
    wa = $urandom; wb = $urandom; sa = 1'b1; sb = 1'b0;
    frame(wa, sa, 1, wb, sb);
    frame(wb, sb, 0, '0, 1'b0);
    abort_frame($urandom);
    frame($urandom, 1'($urandom_range(1)), 0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
